// File: rtl/ipg_pkg.sv
// Shared constants and helpers for the multi-channel IPG message inserter.
// Sync headers, control block type and message field widths.
package ipg_pkg;

   localparam logic [1:0] SYNC_DATA = 2'b10;
   localparam logic [1:0] SYNC_CTRL = 2'b01;

   localparam logic [7:0] BLOCK_TYPE_CTRL    = 8'h1E;
   localparam logic [7:0] IPG_BLOCK_TYPE_DEF = 8'hAA;

   localparam int CHUNK_W = 48;
   localparam int SEQ_W   = 4;
   localparam int CH_W    = 4;

   // An all-idle control block: type 0x1E followed by eight idle characters
   function automatic logic is_idle(
      input logic [1:0]  hdr,
      input logic [63:0] data
   );
      return (hdr == SYNC_CTRL) &&
             (data[7:0] == BLOCK_TYPE_CTRL) &&
             (data[63:8] == 56'd0);
   endfunction

endpackage

// File: rtl/ipg_chan_fifo.sv
// Per-channel synchronous FIFO holding queued IPG message chunks.
// Push to a full FIFO is ignored even if it is popped in the same cycle.
module ipg_chan_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 48,
   localparam int AW = $clog2(DEPTH)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full,
   output logic [AW:0]      level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic             do_push;
   logic             do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == (AW+1)'(DEPTH));
   assign level   = cnt;
   assign head    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/ipg_tx_mux.sv
// Replaces idle control blocks with tagged IPG message blocks drawn
// round-robin from per-channel chunk FIFOs; data blocks pass untouched.
module ipg_tx_mux
   import ipg_pkg::*;
#(
   parameter int          NUM_CH         = 4,
   parameter int          FIFO_DEPTH     = 8,
   parameter int          CHUNK_WIDTH    = 48,
   parameter logic [7:0]  IPG_BLOCK_TYPE = IPG_BLOCK_TYPE_DEF,
   parameter int          MAX_WAIT       = 64,
   parameter int          PAUSE_THRESH   = FIFO_DEPTH - 2
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic [63:0]                   encoded_tx_data,
   input  logic [1:0]                    encoded_tx_hdr,
   input  logic                          blk_valid,
   input  logic [NUM_CH*CHUNK_WIDTH-1:0] memq_data,
   input  logic [NUM_CH-1:0]             memq_valid,
   output logic [NUM_CH-1:0]             memq_ready,
   output logic [63:0]                   proced_encoded_tx_data,
   output logic [1:0]                    proced_encoded_tx_hdr,
   output logic                          proced_valid,
   output logic                          tx_pause,
   output logic [15:0]                   ins_count
);

   localparam int LW    = $clog2(FIFO_DEPTH) + 1;
   localparam int AGE_W = $clog2(MAX_WAIT + 1);
   localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [CHUNK_WIDTH-1:0] head    [NUM_CH];
   logic [LW-1:0]          level   [NUM_CH];
   logic [LW-1:0]          level_n [NUM_CH];
   logic [AGE_W-1:0]       age     [NUM_CH];
   logic [AGE_W-1:0]       age_n   [NUM_CH];
   logic [SEQ_W-1:0]       seq     [NUM_CH];
   logic [NUM_CH-1:0]      empty;
   logic [NUM_CH-1:0]      full;
   logic [NUM_CH-1:0]      push;
   logic [NUM_CH-1:0]      pop;
   logic [PTR_W-1:0]       rr_ptr;
   logic [PTR_W-1:0]       grant;
   logic                   hit;
   logic                   idle;
   logic                   ins;
   logic                   pause_n;

   assign memq_ready = ~full;
   assign push       = memq_valid & ~full;
   assign idle       = blk_valid && is_idle(encoded_tx_hdr, encoded_tx_data);
   assign ins        = idle && hit;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      ipg_chan_fifo #(
         .DEPTH (FIFO_DEPTH),
         .WIDTH (CHUNK_WIDTH)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (push[c]),
         .din   (memq_data[c*CHUNK_WIDTH +: CHUNK_WIDTH]),
         .pop   (pop[c]),
         .head  (head[c]),
         .empty (empty[c]),
         .full  (full[c]),
         .level (level[c])
      );
   end

   // Round-robin: first non-empty channel at or after rr_ptr
   always_comb begin
      int idx;
      idx   = 0;
      hit   = 1'b0;
      grant = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (!hit && !empty[idx]) begin
            hit   = 1'b1;
            grant = PTR_W'(idx);
         end
      end
      pop = '0;
      if (ins) pop[grant] = 1'b1;
   end

   // Pause tracks the state the FIFOs and ages take on after this edge
   always_comb begin
      logic set;
      logic any_q;
      set   = 1'b0;
      any_q = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         level_n[c] = level[c] + LW'(push[c]) - LW'(pop[c]);
         if (empty[c] || pop[c])
            age_n[c] = '0;
         else if (age[c] == AGE_W'(MAX_WAIT))
            age_n[c] = age[c];
         else
            age_n[c] = age[c] + 1'b1;
         if (age_n[c] >= AGE_W'(MAX_WAIT))        set   = 1'b1;
         if (int'(level_n[c]) >= PAUSE_THRESH)    set   = 1'b1;
         if (level_n[c] != '0)                    any_q = 1'b1;
      end
      pause_n = set || (tx_pause && any_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         proced_encoded_tx_data <= '0;
         proced_encoded_tx_hdr  <= '0;
         proced_valid           <= 1'b0;
         tx_pause               <= 1'b0;
         ins_count              <= '0;
         rr_ptr                 <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            seq[c] <= '0;
            age[c] <= '0;
         end
      end else begin
         proced_valid <= blk_valid;
         tx_pause     <= pause_n;
         for (int c = 0; c < NUM_CH; c++) age[c] <= age_n[c];
         if (blk_valid) begin
            if (ins) begin
               proced_encoded_tx_hdr  <= SYNC_CTRL;
               proced_encoded_tx_data <= {head[grant], seq[grant],
                                          CH_W'(grant), IPG_BLOCK_TYPE};
               seq[grant] <= seq[grant] + 1'b1;
               ins_count  <= ins_count + 1'b1;
               if (int'(grant) == NUM_CH - 1)
                  rr_ptr <= '0;
               else
                  rr_ptr <= grant + 1'b1;
            end else begin
               proced_encoded_tx_hdr  <= encoded_tx_hdr;
               proced_encoded_tx_data <= encoded_tx_data;
            end
         end
      end
   end

endmodule

// File: doc/ipg_tx_mux.md
Name: ipg_tx_mux

Overview:
- Multi-channel successor to the single-queue IPG inserter in the 10G PHY TX path.
- Sits between the 64b/66b encoder and the TX interface (scrambler/gearbox).
- Buffers short message chunks from NUM_CH independent memory-side channels in per-channel FIFOs.
- Replaces all-idle control blocks in the encoded stream with tagged IPG message blocks; net data blocks are never delayed or altered.

Parameters:
- NUM_CH, 4, number of chunk channels (1..16).
- FIFO_DEPTH, 8, entries per channel FIFO (power of two, >=2).
- CHUNK_WIDTH, 48, payload bits per chunk (fixed at 48).
- IPG_BLOCK_TYPE, 8'hAA, block-type byte marking an IPG message block.
- MAX_WAIT, 64, head-of-line age in cycles at which pause is requested.
- PAUSE_THRESH, FIFO_DEPTH-2, FIFO level at which pause is requested.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- encoded_tx_data  in  64  block payload from the encoder.
- encoded_tx_hdr  in  2  sync header; 2'b10 = data, 2'b01 = control.
- blk_valid  in  1  input block valid this cycle; gearbox stall when low.
- memq_data  in  NUM_CH*48  per-channel chunk; channel c occupies bits [48c+47:48c].
- memq_valid  in  NUM_CH  per-channel write request.
- memq_ready  out  NUM_CH  per-channel not-full.
- proced_encoded_tx_data  out  64  output block.
- proced_encoded_tx_hdr  out  2  output sync header.
- proced_valid  out  1  output block valid.
- tx_pause  out  1  request to the MAC/encoder to emit idles.
- ins_count  out  16  wrapping count of inserted blocks.

Behaviour:
- Reset: all outputs 0; FIFOs empty; seq counters, age counters and RR pointer 0.
  - Exception: memq_ready is all-ones from the first cycle after reset.
- Latency: exactly 1 cycle, blk_valid to proced_valid. When blk_valid=0 the pipeline holds: proced_valid=0, no dequeue, age counters still increment.
- FIFO write:
  - Channel c accepts a chunk when memq_valid[c] && memq_ready[c].
  - memq_ready[c] = !full, computed from the registered count.
  - A write to a full FIFO is ignored.
  - No bypass: a chunk written at cycle t is eligible for insertion at cycle t+1 at the earliest.
- Idle detection: hdr==2'b01 && data[7:0]==8'h1E && data[63:8]==0. Any other block, including control blocks with non-idle characters, passes through unchanged.
- Insertion:
  - Applies on a valid idle block when at least one FIFO is non-empty.
  - Arbiter is round-robin starting at rr_ptr and picks the first non-empty channel g.
  - Output hdr=2'b01, data={chunk48, seq[g][3:0], g[3:0], IPG_BLOCK_TYPE}.
  - Pop FIFO g; seq[g] increments, wrapping 15->0; rr_ptr becomes (g+1) mod NUM_CH; ins_count increments, wrapping.
  - Otherwise the idle block passes through and rr_ptr is unchanged.
- Simultaneous push and pop on the same FIFO is legal, and the level is unchanged. A full FIFO popped this cycle still refuses a push this cycle.
- Age counters:
  - age[c] is 0 when FIFO c is empty or its head was popped this cycle.
  - Otherwise it increments each cycle, saturating at MAX_WAIT.
- tx_pause (registered): set when any age[c] >= MAX_WAIT or any level >= PAUSE_THRESH; cleared when all FIFOs are empty.
- tx_pause is advisory only: the block never drops or reorders net blocks.
- Reset mid-operation flushes all FIFOs; queued chunks are discarded, not emitted.

Decomposition:
- Shared package ipg_pkg:
  - SYNC_DATA=2'b10, SYNC_CTRL=2'b01.
  - BLOCK_TYPE_CTRL=8'h1E, default IPG_BLOCK_TYPE.
  - Chunk and field widths: CHUNK_W=48, SEQ_W=4, CH_W=4.
- Sub-module ipg_chan_fifo: synchronous FIFO, parameter DEPTH and WIDTH.
  - Outputs head, empty, full, level.
  - Instantiated NUM_CH times via a generate loop.
- Arbiter, idle detect, age/pause logic and output register stay in ipg_tx_mux.

Test Plan:
- Passthrough:
  - Stimulus: data block hdr=10, data=64'h0123456789ABCDEF, no chunks queued.
  - Required: identical block out 1 cycle later; ins_count=0.
- Single insert:
  - Stimulus: push 48'hDEADBEEF0001 on ch2, then an idle block.
  - Required: data=64'hDEADBEEF0001_0_2_AA, hdr=01, ch2 seq becomes 1, ins_count=1.
- Round-robin:
  - Stimulus: one chunk on each of ch0, ch1, ch3, then 3 idles.
  - Required: channel fields 0,1,3 in that order; 4th idle passes through unchanged.
- Full/backpressure:
  - Stimulus: 9 pushes to ch1 with DEPTH=8, no idles.
  - Required: memq_ready[1]=0 after the 8th push; 9th chunk dropped; tx_pause=1 once level>=6.
- Age pause:
  - Stimulus: 1 chunk on ch0, 64 data blocks, then an idle.
  - Required: tx_pause=1 after 64 cycles; chunk inserted on the idle; tx_pause=0 the next cycle.
- Reset/seq wrap:
  - Stimulus: 17 inserts on ch0.
  - Required: seq fields 0..15 then 0.
  - Stimulus: rst with 3 chunks queued.
  - Required: idles pass through unchanged and the seq field restarts at 0.
